mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cray_mem_pkg.sv | 15 +
 rtl/mem_tag_fifo.sv | 61 ++++++
 rtl/mem_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cray_mem_pkg.sv
// Shared owner encoding and default sizing for the memory arbiter slice.
package cray_mem_pkg;

    localparam int MEM_AW         = 22;
    localparam int MEM_DW         = 64;
    localparam int MEM_MAX_OUT    = 4;
    localparam int MEM_STARVE_LIM = 8;

    typedef enum logic [1:0] {
        OWN_FU = 2'd0,
        OWN_IB = 2'd1,
        OWN_IO = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_tag_fifo.sv
// In-order owner tag queue for outstanding reads; one entry per issued read.
module mem_tag_fifo
    import cray_mem_pkg::*;
#(
    parameter int DEPTH = MEM_MAX_OUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  owner_e                   owner_in,
    output owner_e                   owner_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int QW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    owner_e          tags [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            pop_ok;
    logic            push_ok;

    // A pop frees the head slot this cycle, so a push at full is still accepted.
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign empty     = (count == '0);
    assign full      = (count == QW'(DEPTH));
    assign owner_out = tags[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            tags[wr_ptr] <= owner_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + QW'(1);
                2'b01:   count <= count - QW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Three-way memory arbiter (FU, IO, IB) with starvation promotion, a bounded
// number of outstanding reads and in-order routing of read returns.
module mem_arbiter
    import cray_mem_pkg::*;
#(
    parameter int AW         = MEM_AW,
    parameter int DW         = MEM_DW,
    parameter int MAX_OUT    = MEM_MAX_OUT,
    parameter int STARVE_LIM = MEM_STARVE_LIM
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          fu_req,
    input  logic          fu_we,
    input  logic [AW-1:0] fu_addr,
    input  logic [DW-1:0] fu_wdata,
    output logic          fu_gnt,
    output logic          fu_rvld,

    input  logic          ib_req,
    input  logic [AW-1:0] ib_addr,
    output logic          ib_gnt,
    output logic          ib_rvld,

    input  logic          io_req,
    input  logic          io_we,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic          io_gnt,
    output logic          io_rvld,

    output logic [DW-1:0] o_rdata,

    output logic          o_mem_ce,
    output logic          o_mem_wr_en,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wr_data,
    input  logic [DW-1:0] i_mem_rd_data,
    input  logic          i_mem_vld,

    output logic          o_err
);

    localparam int CW = $clog2(STARVE_LIM + 1);
    localparam int QW = $clog2(MAX_OUT) + 1;
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

    logic          fifo_empty;
    logic          fifo_full;
    logic [QW-1:0] fifo_count;
    owner_e        head_owner;

    logic          pop;
    logic          push;
    logic          stray;
    logic          read_ok;
    logic          fu_elig;
    logic          ib_elig;
    logic          io_elig;
    logic          ib_starve;
    logic          io_starve;
    logic          fu_sel;
    logic          ib_sel;
    logic          io_sel;
    logic          any_gnt;

    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    owner_e        sel_owner;

    logic [CW-1:0] ib_wait;
    logic [CW-1:0] io_wait;
    logic          err_q;

    logic          vld_p1;
    logic          we_p1;
    logic [AW-1:0] addr_p1;
    logic [DW-1:0] wdata_p1;

    // A return in the same cycle frees a slot, so a read may issue even at the limit.
    assign pop       = rst && i_mem_vld && !fifo_empty;
    assign stray     = i_mem_vld && (fifo_count == '0);
    assign read_ok   = !fifo_full || pop;

    assign fu_elig   = fu_req && (fu_we || read_ok);
    assign io_elig   = io_req && (io_we || read_ok);
    assign ib_elig   = ib_req && read_ok;
    assign ib_starve = (ib_wait == LIM);
    assign io_starve = (io_wait == LIM);

    always_comb begin
        fu_sel = 1'b0;
        ib_sel = 1'b0;
        io_sel = 1'b0;
        if (rst) begin
            if (ib_starve && ib_elig) begin
                ib_sel = 1'b1;
            end else if (io_starve && io_elig) begin
                io_sel = 1'b1;
            end else if (fu_elig) begin
                fu_sel = 1'b1;
            end else if (io_elig) begin
                io_sel = 1'b1;
            end else if (ib_elig) begin
                ib_sel = 1'b1;
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_owner = OWN_FU;
        if (fu_sel) begin
            sel_we    = fu_we;
            sel_addr  = fu_addr;
            sel_wdata = fu_wdata;
            sel_owner = OWN_FU;
        end else if (io_sel) begin
            sel_we    = io_we;
            sel_addr  = io_addr;
            sel_wdata = io_wdata;
            sel_owner = OWN_IO;
        end else if (ib_sel) begin
            sel_addr  = ib_addr;
            sel_owner = OWN_IB;
        end
    end

    assign any_gnt = fu_sel || ib_sel || io_sel;
    assign push    = any_gnt && !sel_we;

    mem_tag_fifo #(
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .owner_in  (sel_owner),
        .owner_out (head_owner),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // Stage p0 -> p1: granted command registered onto the memory port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1   <= 1'b0;
            we_p1    <= 1'b0;
            addr_p1  <= '0;
            wdata_p1 <= '0;
        end else begin
            vld_p1 <= any_gnt;
            we_p1  <= any_gnt && sel_we;
            if (any_gnt) begin
                addr_p1  <= sel_addr;
                wdata_p1 <= sel_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ib_wait <= '0;
            io_wait <= '0;
            err_q   <= 1'b0;
        end else begin
            if (ib_sel) begin
                ib_wait <= '0;
            end else if (ib_req && !ib_starve) begin
                ib_wait <= ib_wait + CW'(1);
            end
            if (io_sel) begin
                io_wait <= '0;
            end else if (io_req && !io_starve) begin
                io_wait <= io_wait + CW'(1);
            end
            if (stray) begin
                err_q <= 1'b1;
            end
        end
    end

    assign fu_gnt        = fu_sel;
    assign ib_gnt        = ib_sel;
    assign io_gnt        = io_sel;

    assign fu_rvld       = pop && (head_owner == OWN_FU);
    assign ib_rvld       = pop && (head_owner == OWN_IB);
    assign io_rvld       = pop && (head_owner == OWN_IO);
    assign o_rdata       = pop ? i_mem_rd_data : '0;

    assign o_mem_ce      = vld_p1;
    assign o_mem_wr_en   = we_p1;
    assign o_mem_addr    = addr_p1;
    assign o_mem_wr_data = wdata_p1;
    assign o_err         = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: priority, starvation, outstanding limit, return routing, reset.
module tb_mem_arbiter;

    localparam int AW = 22;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          fu_req, fu_we, fu_gnt, fu_rvld;
    logic [AW-1:0] fu_addr;
    logic [DW-1:0] fu_wdata;
    logic          ib_req, ib_gnt, ib_rvld;
    logic [AW-1:0] ib_addr;
    logic          io_req, io_we, io_gnt, io_rvld;
    logic [AW-1:0] io_addr;
    logic [DW-1:0] io_wdata;
    logic [DW-1:0] o_rdata;
    logic          o_mem_ce, o_mem_wr_en;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wr_data;
    logic [DW-1:0] i_mem_rd_data;
    logic          i_mem_vld;
    logic          o_err;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .AW         (AW),
        .DW         (DW),
        .MAX_OUT    (4),
        .STARVE_LIM (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fu_req        (fu_req),
        .fu_we         (fu_we),
        .fu_addr       (fu_addr),
        .fu_wdata      (fu_wdata),
        .fu_gnt        (fu_gnt),
        .fu_rvld       (fu_rvld),
        .ib_req        (ib_req),
        .ib_addr       (ib_addr),
        .ib_gnt        (ib_gnt),
        .ib_rvld       (ib_rvld),
        .io_req        (io_req),
        .io_we         (io_we),
        .io_addr       (io_addr),
        .io_wdata      (io_wdata),
        .io_gnt        (io_gnt),
        .io_rvld       (io_rvld),
        .o_rdata       (o_rdata),
        .o_mem_ce      (o_mem_ce),
        .o_mem_wr_en   (o_mem_wr_en),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wr_data (o_mem_wr_data),
        .i_mem_rd_data (i_mem_rd_data),
        .i_mem_vld     (i_mem_vld),
        .o_err         (o_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr();
        fu_req = 0; fu_we = 0; fu_addr = '0; fu_wdata = '0;
        ib_req = 0; ib_addr = '0;
        io_req = 0; io_we = 0; io_addr = '0; io_wdata = '0;
        i_mem_vld = 0; i_mem_rd_data = '0;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 0;
        clr();
        to_pos();
        to_pos();
        rst = 1;
    endtask

    logic [DW-1:0] rd_tab [4];
    logic [2:0]    rv_tab [4];

    initial begin
        rd_tab[0] = 64'hA5A5A5A5A5A5A5A5; rv_tab[0] = 3'b100;
        rd_tab[1] = 64'h5A5A5A5A5A5A5A5A; rv_tab[1] = 3'b010;
        rd_tab[2] = 64'h0123456789ABCDEF; rv_tab[2] = 3'b001;
        rd_tab[3] = 64'hFEDCBA9876543210; rv_tab[3] = 3'b100;

        // Reset state, with a request held during reset
        clr();
        rst = 0;
        fu_req = 1; fu_addr = 22'h3;
        to_neg();
        chk("rst_gnt", {fu_gnt, ib_gnt, io_gnt}, 3'b000);
        to_pos();
        to_pos();
        chk("rst_ce", o_mem_ce, 0);
        chk("rst_wr_en", o_mem_wr_en, 0);
        chk("rst_addr", o_mem_addr, 0);
        chk("rst_wdata", o_mem_wr_data, 0);
        chk("rst_err", o_err, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_rvld", {fu_rvld, ib_rvld, io_rvld}, 3'b000);

        // All three request: FU first, IO promoted on its 9th waiting cycle
        clr();
        rst = 1;
        fu_req = 1; fu_we = 1; fu_addr = 22'h00100; fu_wdata = 64'h1111;
        io_req = 1; io_we = 1; io_addr = 22'h00200; io_wdata = 64'h2222;
        ib_req = 1; ib_addr = 22'h00300;
        to_neg();
        chk("t1_all3", {fu_gnt, ib_gnt, io_gnt}, 3'b100);
        to_pos();
        chk("t1_ce", o_mem_ce, 1);
        chk("t1_wr_en", o_mem_wr_en, 1);
        chk("t1_addr", o_mem_addr, 22'h00100);
        chk("t1_wdata", o_mem_wr_data, 64'h1111);
        ib_req = 0;
        for (int c = 2; c <= 9; c++) begin
            to_neg();
            chk($sformatf("t1_cyc%0d", c), {fu_gnt, ib_gnt, io_gnt}, (c == 9) ? 3'b001 : 3'b100);
            to_pos();
        end
        chk("t1_io_addr", o_mem_addr, 22'h00200);
        chk("t1_io_wdata", o_mem_wr_data, 64'h2222);
        to_neg();
        chk("t1_after", {fu_gnt, ib_gnt, io_gnt}, 3'b100);
        to_pos();

        // FU and IO held: IB promoted after 8 waits, then counter restarts
        do_reset();
        fu_req = 1; fu_we = 1; fu_addr = 22'h00010; fu_wdata = 64'h10;
        io_req = 1; io_we = 1; io_addr = 22'h00020; io_wdata = 64'h20;
        ib_req = 1; ib_addr = 22'h003AB;
        for (int c = 1; c <= 18; c++) begin
            to_neg();
            chk($sformatf("t2_cyc%0d", c), {fu_gnt, ib_gnt, io_gnt},
                (c == 9 || c == 18) ? 3'b010 : (c == 10) ? 3'b001 : 3'b100);
            to_pos();
            if (c == 9) begin
                chk("t2_ib_addr", o_mem_addr, 22'h003AB);
                chk("t2_ib_rd", o_mem_wr_en, 0);
            end
        end

        // Outstanding limit: 4 IB reads fill the queue
        do_reset();
        ib_req = 1;
        for (int c = 0; c < 4; c++) begin
            ib_addr = 22'h20 + 22'(c);
            to_neg();
            chk($sformatf("t3_rd%0d", c), {fu_gnt, ib_gnt, io_gnt}, 3'b010);
            to_pos();
        end
        to_neg();
        chk("t3_full_blk", {fu_gnt, ib_gnt, io_gnt}, 3'b000);
        to_pos();
        fu_req = 1; fu_we = 1; fu_addr = 22'h55; fu_wdata = 64'h77;
        to_neg();
        chk("t3_wr_pass", {fu_gnt, ib_gnt, io_gnt}, 3'b100);
        to_pos();
        chk("t3_wr_en", o_mem_wr_en, 1);
        chk("t3_wr_addr", o_mem_addr, 22'h55);
        fu_req = 0; fu_we = 0;
        i_mem_vld = 1; i_mem_rd_data = 64'hCAFE;
        to_neg();
        chk("t3_pop_gnt", {fu_gnt, ib_gnt, io_gnt}, 3'b010);
        chk("t3_pop_rvld", {fu_rvld, ib_rvld, io_rvld}, 3'b010);
        chk("t3_pop_data", o_rdata, 64'hCAFE);
        to_pos();
        chk("t3_pop_addr", o_mem_addr, 22'h23);
        chk("t3_pop_rd", o_mem_wr_en, 0);
        i_mem_vld = 0;
        to_neg();
        chk("t3_still_full", {fu_gnt, ib_gnt, io_gnt}, 3'b000);
        to_pos();

        // Interleaved reads return in order to their owners
        do_reset();
        fu_req = 1; fu_we = 0; fu_addr = 22'h1;
        to_neg(); chk("t4_g0", {fu_gnt, ib_gnt, io_gnt}, 3'b100); to_pos();
        fu_req = 0; ib_req = 1; ib_addr = 22'h2;
        to_neg(); chk("t4_g1", {fu_gnt, ib_gnt, io_gnt}, 3'b010); to_pos();
        ib_req = 0; io_req = 1; io_we = 0; io_addr = 22'h3;
        to_neg(); chk("t4_g2", {fu_gnt, ib_gnt, io_gnt}, 3'b001); to_pos();
        io_req = 0; fu_req = 1; fu_addr = 22'h4;
        to_neg(); chk("t4_g3", {fu_gnt, ib_gnt, io_gnt}, 3'b100); to_pos();
        fu_req = 0;
        for (int i = 0; i < 4; i++) begin
            i_mem_vld = 1; i_mem_rd_data = rd_tab[i];
            to_neg();
            chk($sformatf("t4_rvld%0d", i), {fu_rvld, ib_rvld, io_rvld}, rv_tab[i]);
            chk($sformatf("t4_data%0d", i), o_rdata, rd_tab[i]);
            to_pos();
        end
        chk("t4_no_err", o_err, 0);
        i_mem_rd_data = 64'hDEAD;
        to_neg();
        chk("t4_extra_rvld", {fu_rvld, ib_rvld, io_rvld}, 3'b000);
        to_pos();
        chk("t4_extra_err", o_err, 1);
        i_mem_vld = 0;

        // Stray return right after reset
        do_reset();
        chk("t5_err_clr", o_err, 0);
        i_mem_vld = 1; i_mem_rd_data = 64'hBEEF;
        to_neg();
        chk("t5_rvld", {fu_rvld, ib_rvld, io_rvld}, 3'b000);
        chk("t5_rdata", o_rdata, 0);
        to_pos();
        i_mem_vld = 0;
        chk("t5_err", o_err, 1);
        to_pos();
        to_pos();
        chk("t5_err_held", o_err, 1);

        // Reset with two reads in flight drops their tags
        do_reset();
        fu_req = 1; fu_we = 0; fu_addr = 22'h11;
        to_neg(); chk("t6_g0", {fu_gnt, ib_gnt, io_gnt}, 3'b100); to_pos();
        fu_req = 0; io_req = 1; io_we = 0; io_addr = 22'h12;
        to_neg(); chk("t6_g1", {fu_gnt, ib_gnt, io_gnt}, 3'b001); to_pos();
        chk("t6_pre_addr", o_mem_addr, 22'h12);
        io_req = 0;
        rst = 0;
        fu_req = 1; fu_we = 1; fu_addr = 22'h33; fu_wdata = 64'h44;
        to_neg();
        chk("t6_rst_gnt", {fu_gnt, ib_gnt, io_gnt}, 3'b000);
        to_pos();
        chk("t6_ce", o_mem_ce, 0);
        chk("t6_wr_en", o_mem_wr_en, 0);
        chk("t6_addr", o_mem_addr, 0);
        chk("t6_wdata", o_mem_wr_data, 0);
        chk("t6_err0", o_err, 0);
        rst = 1;
        clr();
        for (int i = 0; i < 2; i++) begin
            i_mem_vld = 1; i_mem_rd_data = 64'h99;
            to_neg();
            chk($sformatf("t6_stray_rvld%0d", i), {fu_rvld, ib_rvld, io_rvld}, 3'b000);
            to_pos();
            chk($sformatf("t6_stray_err%0d", i), o_err, 1);
        end
        i_mem_vld = 0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
